// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the CPU-to-memory handshake controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   // Value returned to the CPU after any read that did not complete cleanly.
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   // Number of low byte-address bits that must be zero for a word access.
   localparam int ALIGN_BITS = 2;

   // A word access is legal only when the byte-offset bits are all zero.
   function automatic logic isAligned(input logic [31:0] addr);
      return (addr[ALIGN_BITS-1:0] == '0);
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles and flags the cycle on which the access must be abandoned.
module mem_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] r_count;
   logic          w_terminal;

   assign w_terminal = (r_count == CW'(TIMEOUT - 1));
   assign o_terminal = w_terminal;

   // Clear at access start, then count up and park at the terminal value so it can never wrap.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_terminal) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Turns the CPU's single-cycle memory access into a req/ack handshake with a
// variable-latency memory, stalling the CPU until the access finishes.
module mem_handshake_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int          ADDR_W   = 10,
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_done,
   output logic              cpu_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   state_t              r_state;
   state_t              w_nextState;
   logic                w_startAccess;
   logic                w_misalign;
   logic                w_ackDone;
   logic                w_timeout;
   logic                w_stall;
   logic                w_terminal;
   logic                w_aligned;

   logic [31:0]         r_rdata;
   logic                r_err;
   logic                r_memReq;
   logic                r_memWe;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [31:0]         r_memWdata;

   assign w_aligned = isAligned(cpu_addr);

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_startAccess),
      .i_enable   (r_state == ST_BUSY),
      .o_terminal (w_terminal)
   );

   // State register; reset always lands in IDLE so an interrupted access never reports done.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode plus the one-cycle event strobes that steer the datapath registers.
   always_comb begin
      w_nextState   = r_state;
      w_startAccess = 1'b0;
      w_misalign    = 1'b0;
      w_ackDone     = 1'b0;
      w_timeout     = 1'b0;
      w_stall       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cpu_req) begin
               w_stall = 1'b1;
               if (w_aligned) begin
                  w_startAccess = 1'b1;
                  w_nextState   = ST_BUSY;
               end else begin
                  w_misalign  = 1'b1;
                  w_nextState = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            if (mem_ack) begin
               w_ackDone   = 1'b1;
               w_nextState = ST_DONE;
            end else if (w_terminal) begin
               w_timeout   = 1'b1;
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Memory-side request registers, CPU error flag and the registered read-data return.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
      end else begin
         if (w_startAccess) begin
            r_memReq   <= 1'b1;
            r_memWe    <= cpu_we;
            r_memAddr  <= cpu_addr[ADDR_W+1:2];
            r_memWdata <= cpu_wdata;
         end else if (w_ackDone || w_timeout) begin
            r_memReq <= 1'b0;
         end
         r_err <= w_misalign || w_timeout;
         if ((w_misalign && !cpu_we) || (w_timeout && !r_memWe)) begin
            r_rdata <= ERR_DATA;
         end else if (w_ackDone && !r_memWe) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   assign cpu_rdata = r_rdata;
   assign cpu_stall = w_stall;
   assign cpu_done  = (r_state == ST_DONE);
   assign cpu_err   = r_err;
   assign mem_req   = r_memReq;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Self-checking bench for mem_handshake_ctrl: each scenario task drives the CPU
// and memory sides and compares against a scoreboard of expected completions.
module tb_mem_handshake_ctrl;

   localparam int ADDR_W = 10;
   localparam int TIMEOUT = 16;
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } expect_t;

   logic              clk;
   logic              reset;
   logic              cpu_req;
   logic              cpu_we;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_stall;
   logic              cpu_done;
   logic              cpu_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   int checks = 0;
   int failures = 0;
   expect_t sbQueue[$];

   mem_handshake_ctrl #(
      .ADDR_W   (ADDR_W),
      .TIMEOUT  (TIMEOUT),
      .ERR_DATA (ERR_DATA)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .cpu_done  (cpu_done),
      .cpu_err   (cpu_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issues one CPU access and plays the memory side, acking on BUSY cycle ackAt
   // (0 = never). Reports what was observed; callers do the comparisons.
   task automatic runAccess(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ackAt,
                            input logic [31:0] ackData,
                            output bit gotDone, output logic errSeen,
                            output logic [31:0] rdataSeen, output int reqCycles,
                            output int latency, output int stallCycles,
                            output logic weSeen, output logic [ADDR_W-1:0] addrSeen,
                            output logic [31:0] wdataSeen);
      gotDone = 0; errSeen = 1'bx; rdataSeen = 'x;
      reqCycles = 0; latency = 0; stallCycles = 0;
      weSeen = 1'bx; addrSeen = 'x; wdataSeen = 'x;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      @(negedge clk);
      if (cpu_stall) stallCycles++;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         cpu_req = 1'b0;
         if (mem_req && (reqCycles + 1 == ackAt)) begin
            mem_ack = 1'b1; mem_rdata = ackData;
         end else begin
            mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
         end
         @(negedge clk);
         if (mem_req) begin
            if (reqCycles == 0) begin
               weSeen = mem_we; addrSeen = mem_addr; wdataSeen = mem_wdata;
            end
            reqCycles++;
         end
         if (cpu_stall) stallCycles++;
         if (cpu_done) begin
            gotDone = 1; errSeen = cpu_err; rdataSeen = cpu_rdata; latency = c;
            break;
         end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      @(negedge clk);
      checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h want=%h", cpu_rdata, 32'h0); end
      checks++; if (cpu_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", cpu_done); end
      checks++; if (cpu_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", cpu_err); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req got=%b want=0", mem_req); end
      checks++; if ({mem_we, mem_addr, mem_wdata} !== '0) begin failures++; $display("[TB] FAIL reset_mem_regs got=%b/%h/%h want=0", mem_we, mem_addr, mem_wdata); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b want=0", cpu_stall); end
   endtask

   task automatic test_read_ack3();
      bit gd; logic e; logic [31:0] rd; int rq, lat, st; logic w; logic [ADDR_W-1:0] a; logic [31:0] wd;
      expect_t exp;
      sbQueue.push_back('{err: 1'b0, rdata: 32'h0000_003A});
      runAccess(1'b0, 32'h0000_0010, 32'h0, 3, 32'h0000_003A, gd, e, rd, rq, lat, st, w, a, wd);
      checks++; if (!gd) begin failures++; $display("[TB] FAIL read_done_timeout got=no_done want=done"); end
      exp = sbQueue.pop_front();
      checks++; if (e !== exp.err) begin failures++; $display("[TB] FAIL read_err got=%b want=%b", e, exp.err); end
      checks++; if (rd !== exp.rdata) begin failures++; $display("[TB] FAIL read_rdata got=%h want=%h", rd, exp.rdata); end
      checks++; if (lat != 4) begin failures++; $display("[TB] FAIL read_latency got=%0d want=4", lat); end
      checks++; if (rq != 3) begin failures++; $display("[TB] FAIL read_req_cycles got=%0d want=3", rq); end
      checks++; if (a !== 10'd4 || w !== 1'b0) begin failures++; $display("[TB] FAIL read_mem_addr got=%0d/%b want=4/0", a, w); end
      checks++; if (st != 4) begin failures++; $display("[TB] FAIL read_stall_cycles got=%0d want=4", st); end
   endtask

   task automatic test_write_immediate();
      bit gd; logic e; logic [31:0] rd; int rq, lat, st; logic w; logic [ADDR_W-1:0] a; logic [31:0] wd;
      expect_t exp;
      sbQueue.push_back('{err: 1'b0, rdata: 32'h0000_003A});
      runAccess(1'b1, 32'h0000_0100, 32'h1234_5678, 1, 32'hFFFF_FFFF, gd, e, rd, rq, lat, st, w, a, wd);
      exp = sbQueue.pop_front();
      checks++; if (!gd || lat != 2) begin failures++; $display("[TB] FAIL write_latency got=%0d/%0d want=1/2", gd, lat); end
      checks++; if (w !== 1'b1 || a !== 10'd64 || wd !== 32'h1234_5678) begin failures++; $display("[TB] FAIL write_mem_fields got=%b/%0d/%h want=1/64/12345678", w, a, wd); end
      checks++; if (e !== exp.err) begin failures++; $display("[TB] FAIL write_err got=%b want=%b", e, exp.err); end
      checks++; if (rd !== exp.rdata) begin failures++; $display("[TB] FAIL write_rdata_kept got=%h want=%h", rd, exp.rdata); end
   endtask

   task automatic test_misaligned();
      bit gd; logic e; logic [31:0] rd; int rq, lat, st; logic w; logic [ADDR_W-1:0] a; logic [31:0] wd;
      expect_t exp;
      sbQueue.push_back('{err: 1'b1, rdata: ERR_DATA});
      runAccess(1'b0, 32'h0000_0006, 32'h0, 1, 32'h1111_1111, gd, e, rd, rq, lat, st, w, a, wd);
      exp = sbQueue.pop_front();
      checks++; if (rq != 0) begin failures++; $display("[TB] FAIL misalign_no_req got=%0d want=0", rq); end
      checks++; if (!gd || lat != 1) begin failures++; $display("[TB] FAIL misalign_latency got=%0d/%0d want=1/1", gd, lat); end
      checks++; if (e !== exp.err) begin failures++; $display("[TB] FAIL misalign_err got=%b want=%b", e, exp.err); end
      checks++; if (rd !== exp.rdata) begin failures++; $display("[TB] FAIL misalign_rdata got=%h want=%h", rd, exp.rdata); end
   endtask

   task automatic test_ack_timeout_coincide();
      bit gd; logic e; logic [31:0] rd; int rq, lat, st; logic w; logic [ADDR_W-1:0] a; logic [31:0] wd;
      expect_t exp;
      sbQueue.push_back('{err: 1'b0, rdata: 32'h0000_0055});
      runAccess(1'b0, 32'h0000_0040, 32'h0, TIMEOUT, 32'h0000_0055, gd, e, rd, rq, lat, st, w, a, wd);
      exp = sbQueue.pop_front();
      checks++; if (rq != TIMEOUT || lat != TIMEOUT + 1) begin failures++; $display("[TB] FAIL coincide_timing got=%0d/%0d want=%0d/%0d", rq, lat, TIMEOUT, TIMEOUT + 1); end
      checks++; if (e !== exp.err) begin failures++; $display("[TB] FAIL coincide_err got=%b want=%b", e, exp.err); end
      checks++; if (rd !== exp.rdata) begin failures++; $display("[TB] FAIL coincide_rdata got=%h want=%h", rd, exp.rdata); end
   endtask

   task automatic test_timeout();
      bit gd; logic e; logic [31:0] rd; int rq, lat, st; logic w; logic [ADDR_W-1:0] a; logic [31:0] wd;
      expect_t exp;
      sbQueue.push_back('{err: 1'b1, rdata: ERR_DATA});
      runAccess(1'b0, 32'h0000_0020, 32'h0, 0, 32'h0, gd, e, rd, rq, lat, st, w, a, wd);
      exp = sbQueue.pop_front();
      checks++; if (rq != TIMEOUT) begin failures++; $display("[TB] FAIL timeout_req_cycles got=%0d want=%0d", rq, TIMEOUT); end
      checks++; if (!gd || lat != TIMEOUT + 1) begin failures++; $display("[TB] FAIL timeout_latency got=%0d/%0d want=1/%0d", gd, lat, TIMEOUT + 1); end
      checks++; if (e !== exp.err) begin failures++; $display("[TB] FAIL timeout_err got=%b want=%b", e, exp.err); end
      checks++; if (rd !== exp.rdata) begin failures++; $display("[TB] FAIL timeout_rdata got=%h want=%h", rd, exp.rdata); end
      @(negedge clk);
      checks++; if (cpu_done !== 1'b0 || cpu_stall !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL timeout_back_idle got=%b%b%b want=000", cpu_done, cpu_stall, mem_req); end
   endtask

   task automatic test_reset_mid_access();
      bit gd; logic e; logic [31:0] rd; int rq, lat, st; logic w; logic [ADDR_W-1:0] a; logic [31:0] wd;
      expect_t exp;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0044; cpu_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL midreset_busy got=%b want=1", mem_req); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || cpu_done !== 1'b0 || cpu_err !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ctrl got=%b%b%b want=000", mem_req, cpu_done, cpu_err); end
      checks++; if ({mem_we, mem_addr, mem_wdata, cpu_rdata} !== '0) begin failures++; $display("[TB] FAIL midreset_regs got=%b/%h/%h/%h want=0", mem_we, mem_addr, mem_wdata, cpu_rdata); end
      sbQueue.push_back('{err: 1'b0, rdata: 32'h0000_0099});
      runAccess(1'b0, 32'h0000_0008, 32'h0, 2, 32'h0000_0099, gd, e, rd, rq, lat, st, w, a, wd);
      exp = sbQueue.pop_front();
      checks++; if (!gd || lat != 3 || e !== exp.err || rd !== exp.rdata) begin failures++; $display("[TB] FAIL midreset_recover got=%0d/%0d/%b/%h want=1/3/%b/%h", gd, lat, e, rd, exp.err, exp.rdata); end
   endtask

   task automatic test_back_to_back();
      bit gd; logic e; logic [31:0] rd; int rq, lat, st; logic w; logic [ADDR_W-1:0] a; logic [31:0] wd;
      expect_t exp;
      logic [31:0] pattern [3] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
      // Memory ack while IDLE must not produce a completion.
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      checks++; if (cpu_done !== 1'b0 || cpu_rdata !== 32'h0000_0099) begin failures++; $display("[TB] FAIL idle_ack_ignored got=%b/%h want=0/00000099", cpu_done, cpu_rdata); end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sbQueue.push_back('{err: 1'b0, rdata: pattern[i]});
         runAccess(1'b0, 32'h0000_0200 + 32'(i * 4), 32'h0, 1, pattern[i], gd, e, rd, rq, lat, st, w, a, wd);
         exp = sbQueue.pop_front();
         checks++; if (!gd || lat != 2 || a !== ADDR_W'(128 + i) || e !== exp.err || rd !== exp.rdata) begin
            failures++;
            $display("[TB] FAIL b2b_%0d got=%0d/%0d/%0d/%b/%h want=1/2/%0d/%b/%h", i, gd, lat, a, e, rd, 128 + i, exp.err, exp.rdata);
         end
      end
   endtask

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_read_ack3();
      test_write_immediate();
      test_misaligned();
      test_ack_timeout_coincide();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_handshake_ctrl.md
Name: mem_handshake_ctrl

Overview:
- Sits between the multicycle CPU's memory-address/data path and a variable-latency word memory.
- Converts the CPU's single-cycle memory access into a req/ack handshake.
- Drives cpu_stall so the control FSM holds its state until the access completes.
- Adds alignment checking, a timeout, and a registered read-data return.

Parameters:
- ADDR_W, 10: word-address width presented to memory (byte address bits [ADDR_W+1:2]).
- TIMEOUT, 16: number of BUSY cycles without mem_ack before the access is aborted; minimum 2.
- ERR_DATA, 32'hDEADBEEF: value returned on cpu_rdata after any errored read.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request, sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  registered read data.
- cpu_stall  out  1  CPU must hold state while high.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done: misaligned or timeout.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  latched write enable.
- mem_addr  out  ADDR_W  latched word address.
- mem_wdata  out  32  latched write data.
- mem_ack  in  1  memory completion; read data is valid on mem_rdata in the same cycle.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset state is IDLE.
- Reset values: cpu_rdata=0, cpu_done=0, cpu_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- State encoding: IDLE, BUSY, DONE.
- IDLE, cpu_req=1, cpu_addr[1:0]==0:
  - latch cpu_we, cpu_addr[ADDR_W+1:2] and cpu_wdata into the mem_* registers;
  - next state BUSY, mem_req=1, counter cleared.
- IDLE, cpu_req=1, cpu_addr[1:0]!=0:
  - no memory request is issued;
  - next state DONE with cpu_err=1;
  - for a read, cpu_rdata=ERR_DATA.
- BUSY:
  - mem_req and the mem_* outputs are held stable; counter increments every cycle.
  - mem_ack=1: mem_req drops at the next edge. For a read, cpu_rdata<=mem_rdata. Next state DONE, cpu_err=0.
  - mem_ack=0 and counter==TIMEOUT-1: abort. mem_req drops; next state DONE with cpu_err=1; for a read, cpu_rdata<=ERR_DATA.
  - mem_ack on the first BUSY cycle is legal.
  - If ack and timeout occur in the same cycle, ack wins (no error).
- DONE:
  - cpu_done=1 and cpu_err holds its latched value for exactly this cycle; next state IDLE.
  - cpu_req is ignored in DONE; the CPU re-presents it in IDLE.
- cpu_rdata:
  - updates only on a read completion (successful or errored);
  - writes leave it unchanged;
  - holds until the next read completion.
- cpu_stall is combinational: 1 when (state==IDLE and cpu_req) or state==BUSY; 0 in DONE.
- Latency: request in IDLE at cycle 0; earliest ack at cycle 1; done at cycle 2; IDLE at cycle 3. Back-to-back throughput is one access per 3 cycles minimum.
- mem_ack outside BUSY is ignored.
- Reset mid-access (any state) returns to IDLE next edge. mem_req deasserts; no cpu_done is produced.
- Counter width: $clog2(TIMEOUT)+1 bits; it never wraps.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - ERR_DATA default;
  - word-alignment constant (2 low address bits).
- One natural sub-module, mem_timeout_counter: clear/enable inputs, terminal-count output at TIMEOUT-1.
- Everything else stays in mem_handshake_ctrl.

Test Plan:
- Read, ack after 3 cycles: cpu_req=1, we=0, addr=32'h0000_0010 at cycle 0. mem_addr=4 and mem_req=1 for cycles 1-3, mem_ack=1 with mem_rdata=32'h0000_003A at cycle 3. Then cpu_done=1, cpu_err=0 at cycle 4; cpu_rdata=32'h3A; cpu_stall high for cycles 0-3.
- Write, immediate ack: we=1, addr=32'h0000_0100, wdata=32'h1234_5678. mem_we=1, mem_addr=64, mem_wdata=32'h12345678 at cycle 1; ack at cycle 1; done at cycle 2; cpu_rdata unchanged.
- Misaligned: addr=32'h0000_0006, read. mem_req never asserts; at cycle 1 cpu_done=1, cpu_err=1, cpu_rdata=32'hDEADBEEF.
- Timeout: read with mem_ack held 0. mem_req high for exactly 16 cycles; then cpu_done=1, cpu_err=1, cpu_rdata=ERR_DATA; state returns to IDLE.
- Ack and timeout coincide: mem_ack=1 on BUSY cycle 16 with mem_rdata=32'h55. Result is cpu_err=0 and cpu_rdata=32'h55.
- Reset mid-access: assert reset on BUSY cycle 2. Next edge: mem_req=0, cpu_done=0, all outputs at reset values; a new request afterwards completes normally.
